// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Ports: if_* fetch side, dm_* data side, mem_* shared port, flush/stall/err control.
module mem_port_arbiter #(
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic [31:0] if_rdata_out,
  output logic        if_ack_out,
  input  logic        dm_req_in,
  input  logic        dm_we_in,
  input  logic [31:0] dm_addr_in,
  input  logic [31:0] dm_wdata_in,
  output logic [31:0] dm_rdata_out,
  output logic        dm_ack_out,
  input  logic        flush_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ready_in,
  output logic        stall_out,
  output logic        err_out
);

  localparam int SW = $clog2(STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nx;
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] wait_nx;
  logic          kill;
  logic          kill_nx;
  logic          req_nx;
  logic          we_nx;
  logic [31:0]   addr_nx;
  logic [31:0]   wdata_nx;
  logic [31:0]   rdata;
  logic [31:0]   rdata_nx;
  logic          err_nx;
  logic          if_ack_nx;
  logic          dm_ack_nx;
  logic          grant_dm;
  logic          grant_if;

  // Data wins unless a fetch has waited out a full streak.
  // The two grants are mutually exclusive by construction.
  assign grant_dm = dm_req_in &
                    (~if_req_in | (streak < STREAK_MAX));
  assign grant_if = if_req_in & ~flush_in &
                    (~dm_req_in | (streak == STREAK_MAX));

  assign if_rdata_out = rdata;
  assign dm_rdata_out = rdata;

  assign stall_out = (if_req_in & ~if_ack_out & ~flush_in) |
                     (dm_req_in & ~dm_ack_out);

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    wait_nx   = wait_cnt;
    kill_nx   = kill;
    req_nx    = mem_req_out;
    we_nx     = mem_we_out;
    addr_nx   = mem_addr_out;
    wdata_nx  = mem_wdata_out;
    rdata_nx  = rdata;
    err_nx    = 1'b0;
    if_ack_nx = 1'b0;
    dm_ack_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nx = BUSY_DM;
          req_nx   = 1'b1;
          we_nx    = dm_we_in;
          addr_nx  = dm_addr_in;
          wdata_nx = dm_wdata_in;
          wait_nx  = '0;
          kill_nx  = 1'b0;
          if (!if_req_in) begin
            streak_nx = '0;
          end else if (streak != STREAK_MAX) begin
            streak_nx = streak + 1'b1;
          end
        end else if (grant_if) begin
          state_nx  = BUSY_IF;
          req_nx    = 1'b1;
          we_nx     = 1'b0;
          addr_nx   = if_addr_in;
          wdata_nx  = '0;
          wait_nx   = '0;
          kill_nx   = 1'b0;
          streak_nx = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        // A flush cannot cancel the bus cycle already in
        // flight; it only hides the completion from fetch.
        if (state == BUSY_IF && flush_in) begin
          kill_nx = 1'b1;
        end
        if (!mem_ready_in) begin
          wait_nx = wait_cnt + 1'b1;
        end
        if (mem_ready_in || wait_cnt == WAIT_LAST) begin
          state_nx = DONE;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          rdata_nx = mem_ready_in ? mem_rdata_in : '0;
          if (state == BUSY_IF) begin
            if_ack_nx = ~kill_nx;
          end else begin
            dm_ack_nx = 1'b1;
          end
          // err only ever qualifies an ack that is delivered.
          err_nx = ~mem_ready_in & (if_ack_nx | dm_ack_nx);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state         <= IDLE;
      streak        <= '0;
      wait_cnt      <= '0;
      kill          <= 1'b0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      rdata         <= '0;
      err_out       <= 1'b0;
      if_ack_out    <= 1'b0;
      dm_ack_out    <= 1'b0;
    end else begin
      state         <= state_nx;
      streak        <= streak_nx;
      wait_cnt      <= wait_nx;
      kill          <= kill_nx;
      mem_req_out   <= req_nx;
      mem_we_out    <= we_nx;
      mem_addr_out  <= addr_nx;
      mem_wdata_out <= wdata_nx;
      rdata         <= rdata_nx;
      err_out       <= err_nx;
      if_ack_out    <= if_ack_nx;
      dm_ack_out    <= dm_ack_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue scoreboard
// checked by an independent ack monitor.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic [31:0] if_rdata_out;
  logic        if_ack_out;
  logic        dm_req_in = 1'b0;
  logic        dm_we_in = 1'b0;
  logic [31:0] dm_addr_in = '0;
  logic [31:0] dm_wdata_in = '0;
  logic [31:0] dm_rdata_out;
  logic        dm_ack_out;
  logic        flush_in = 1'b0;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in = '0;
  logic        mem_ready_in = 1'b0;
  logic        stall_out;
  logic        err_out;

  mem_port_arbiter #(
    .STREAK (4),
    .TIMEOUT(255)
  ) dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_rdata_out (if_rdata_out),
    .if_ack_out   (if_ack_out),
    .dm_req_in    (dm_req_in),
    .dm_we_in     (dm_we_in),
    .dm_addr_in   (dm_addr_in),
    .dm_wdata_in  (dm_wdata_in),
    .dm_rdata_out (dm_rdata_out),
    .dm_ack_out   (dm_ack_out),
    .flush_in     (flush_in),
    .mem_req_out  (mem_req_out),
    .mem_we_out   (mem_we_out),
    .mem_addr_out (mem_addr_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in (mem_rdata_in),
    .mem_ready_in (mem_ready_in),
    .stall_out    (stall_out),
    .err_out      (err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        dm;
    logic        err;
    logic        chk_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic expect_ack(input logic dm,
                            input logic err,
                            input logic chk_data,
                            input logic [31:0] rdata);
    exp_t e;
    e.dm       = dm;
    e.err      = err;
    e.chk_data = chk_data;
    e.rdata    = rdata;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (reset_n_in && (if_ack_out || dm_ack_out)) begin
        chk("ack_excl", 32'(if_ack_out & dm_ack_out), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ack: got if=%0b dm=%0b want none",
                   if_ack_out, dm_ack_out);
        end else begin
          e = sb.pop_front();
          chk("ack_side", 32'(dm_ack_out), 32'(e.dm));
          chk("ack_err", 32'(err_out), 32'(e.err));
          if (e.chk_data) begin
            chk("ack_rdata",
                dm_ack_out ? dm_rdata_out : if_rdata_out,
                e.rdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int cnt;

    // reset state
    cyc(3);
    chk("rst_req", 32'(mem_req_out), 32'd0);
    chk("rst_we", 32'(mem_we_out), 32'd0);
    chk("rst_addr", mem_addr_out, 32'd0);
    chk("rst_acks", 32'({if_ack_out, dm_ack_out, err_out}), 32'd0);
    chk("rst_rdata", dm_rdata_out, 32'd0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    cyc();

    // single load, ready one cycle after mem_req_out
    dm_req_in  = 1'b1;
    dm_addr_in = 32'h0000_0100;
    expect_ack(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc();
    chk("ld_req", 32'(mem_req_out), 32'd1);
    chk("ld_addr", mem_addr_out, 32'h0000_0100);
    chk("ld_we", 32'(mem_we_out), 32'd0);
    chk("ld_stall", 32'(stall_out), 32'd1);
    cyc();
    chk("ld_req2", 32'(mem_req_out), 32'd1);
    chk("ld_noack", 32'(dm_ack_out), 32'd0);
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'hDEAD_BEEF;
    cyc();
    mem_ready_in = 1'b0;
    mem_rdata_in = '0;
    chk("ld_ack_c3", 32'(dm_ack_out), 32'd1);
    chk("ld_rdata", dm_rdata_out, 32'hDEAD_BEEF);
    chk("ld_req_off", 32'(mem_req_out), 32'd0);
    dm_req_in = 1'b0;
    cyc();
    chk("ld_stall_after", 32'(stall_out), 32'd0);
    chk("ld_pulse", 32'(dm_ack_out), 32'd0);
    cyc();

    // store held over a three-cycle window
    dm_req_in   = 1'b1;
    dm_we_in    = 1'b1;
    dm_addr_in  = 32'h0000_0104;
    dm_wdata_in = 32'h1234_5678;
    expect_ack(1'b1, 1'b0, 1'b0, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("st_req", 32'(mem_req_out), 32'd1);
      chk("st_we", 32'(mem_we_out), 32'd1);
      chk("st_wdata", mem_wdata_out, 32'h1234_5678);
      if (i == 2) mem_ready_in = 1'b1;
      cyc();
    end
    mem_ready_in = 1'b0;
    chk("st_ack", 32'(dm_ack_out), 32'd1);
    chk("st_err", 32'(err_out), 32'd0);
    chk("st_we_off", 32'(mem_we_out), 32'd0);
    dm_req_in = 1'b0;
    dm_we_in  = 1'b0;
    cyc(2);

    // flush in IDLE blocks the fetch grant for that cycle
    if_req_in  = 1'b1;
    if_addr_in = 32'h0000_1000;
    flush_in   = 1'b1;
    #1;
    chk("fl_idle_stall", 32'(stall_out), 32'd0);
    cyc();
    chk("fl_idle_block", 32'(mem_req_out), 32'd0);
    flush_in = 1'b0;
    expect_ack(1'b0, 1'b0, 1'b1, 32'h600D_F00D);
    cyc();
    chk("if_req", 32'(mem_req_out), 32'd1);
    chk("if_we", 32'(mem_we_out), 32'd0);
    chk("if_addr", mem_addr_out, 32'h0000_1000);
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'h600D_F00D;
    cyc();
    mem_ready_in = 1'b0;
    chk("if_ack", 32'(if_ack_out), 32'd1);
    if_req_in = 1'b0;
    cyc(2);

    // flush during BUSY_IF: bus completes, ack suppressed
    if_req_in  = 1'b1;
    if_addr_in = 32'h0000_2000;
    cyc();
    chk("kill_req", 32'(mem_req_out), 32'd1);
    flush_in = 1'b1;
    #1;
    chk("kill_stall", 32'(stall_out), 32'd0);
    cyc();
    flush_in     = 1'b0;
    if_req_in    = 1'b0;
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'hCAFE_F00D;
    chk("kill_req2", 32'(mem_req_out), 32'd1);
    cyc();
    mem_ready_in = 1'b0;
    chk("kill_noack", 32'(if_ack_out), 32'd0);
    chk("kill_req_off", 32'(mem_req_out), 32'd0);
    chk("kill_stall2", 32'(stall_out), 32'd0);
    cyc(2);

    // requester drops mid-transaction, minimum latency
    dm_req_in  = 1'b1;
    dm_addr_in = 32'h0000_0108;
    expect_ack(1'b1, 1'b0, 1'b1, 32'h0F0F_0F0F);
    cyc();
    dm_req_in    = 1'b0;
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'h0F0F_0F0F;
    chk("drop_req", 32'(mem_req_out), 32'd1);
    cyc();
    mem_ready_in = 1'b0;
    chk("drop_ack_c2", 32'(dm_ack_out), 32'd1);
    cyc(2);

    // contention with immediate ready: D D D D I D D D D I
    for (int i = 0; i < 10; i++) begin
      expect_ack((i % 5) != 4, 1'b0, 1'b1, 32'h5555_AAAA);
    end
    dm_req_in    = 1'b1;
    if_req_in    = 1'b1;
    dm_addr_in   = 32'h0000_0200;
    if_addr_in   = 32'h0000_0400;
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'h5555_AAAA;
    n = 0;
    for (int i = 0; i < 100 && n < 10; i++) begin
      cyc();
      if (if_ack_out || dm_ack_out) n++;
    end
    dm_req_in    = 1'b0;
    if_req_in    = 1'b0;
    mem_ready_in = 1'b0;
    mem_rdata_in = '0;
    chk("cont_acks", 32'(n), 32'd10);
    cyc(2);

    // timeout abort
    dm_req_in    = 1'b1;
    dm_addr_in   = 32'h0000_0300;
    mem_rdata_in = 32'hFFFF_FFFF;
    expect_ack(1'b1, 1'b1, 1'b1, 32'd0);
    cyc();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mem_req_out) break;
      cnt++;
      cyc();
    end
    chk("to_cycles", 32'(cnt), 32'd255);
    chk("to_ack", 32'(dm_ack_out), 32'd1);
    chk("to_err", 32'(err_out), 32'd1);
    chk("to_rdata", dm_rdata_out, 32'd0);
    dm_req_in    = 1'b0;
    mem_rdata_in = '0;
    cyc(2);

    // async reset in the middle of BUSY_DM
    dm_req_in   = 1'b1;
    dm_we_in    = 1'b1;
    dm_addr_in  = 32'h0000_0400;
    dm_wdata_in = 32'h0BAD_C0DE;
    cyc();
    chk("ar_busy", 32'(mem_req_out), 32'd1);
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req_out), 32'd0);
    chk("ar_we", 32'(mem_we_out), 32'd0);
    chk("ar_addr", mem_addr_out, 32'd0);
    chk("ar_wdata", mem_wdata_out, 32'd0);
    chk("ar_acks", 32'({if_ack_out, dm_ack_out, err_out}), 32'd0);
    dm_req_in = 1'b0;
    dm_we_in  = 1'b0;
    cyc(2);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ar_quiet", 32'({mem_req_out, dm_ack_out}), 32'd0);
    end

    // grant on the first edge after release
    reset_n_in = 1'b0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    dm_req_in  = 1'b1;
    dm_addr_in = 32'h0000_0500;
    expect_ack(1'b1, 1'b0, 1'b1, 32'h55AA_55AA);
    cyc();
    chk("rel_req", 32'(mem_req_out), 32'd1);
    chk("rel_addr", mem_addr_out, 32'h0000_0500);
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'h55AA_55AA;
    cyc();
    mem_ready_in = 1'b0;
    chk("rel_ack", 32'(dm_ack_out), 32'd1);
    dm_req_in = 1'b0;
    cyc(3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
